// File: rtl/mem_access_unit.sv
// Load/store unit: one Avalon-MM style transaction per request, with byte-lane steering,
// sign/zero extension and LWL/LWR merging of the returned word.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic [5:0]  opcode_i,
  input  logic [31:0] effective_address_i,
  input  logic [31:0] rt_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] data_o,
  output logic        addr_err_o,
  output logic [31:0] address_o,
  output logic        read_o,
  output logic        write_o,
  output logic [3:0]  byteenable_o,
  output logic [31:0] writedata_o,
  input  logic        waitrequest_i,
  input  logic [31:0] readdata_i
);

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLwl = 6'h22;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpLwr = 6'h26;
  localparam logic [5:0] OpSb  = 6'h28;
  localparam logic [5:0] OpSh  = 6'h29;
  localparam logic [5:0] OpSw  = 6'h2B;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  // Request decode straight from the inputs, used only in the accepting cycle.
  logic [1:0]  req_off;
  logic        req_err;
  logic        req_load;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  assign req_off = effective_address_i[1:0];

  always_comb begin
    req_err   = 1'b0;
    req_load  = 1'b0;
    req_be    = 4'b0000;
    req_wdata = 32'h0;
    case (opcode_i)
      OpLb, OpLbu: begin
        req_load = 1'b1;
        req_be   = 4'b0001 << req_off;
      end
      OpLh, OpLhu: begin
        req_load = 1'b1;
        req_err  = req_off[0];
        req_be   = 4'b0011 << req_off;
      end
      OpLw: begin
        req_load = 1'b1;
        req_err  = |req_off;
        req_be   = 4'b1111;
      end
      OpLwl: begin
        req_load = 1'b1;
        case (req_off)
          2'd0:    req_be = 4'b0001;
          2'd1:    req_be = 4'b0011;
          2'd2:    req_be = 4'b0111;
          default: req_be = 4'b1111;
        endcase
      end
      OpLwr: begin
        req_load = 1'b1;
        req_be   = 4'b1111 << req_off;
      end
      OpSb: begin
        req_be    = 4'b0001 << req_off;
        req_wdata = rt_i << {req_off, 3'b000};
      end
      OpSh: begin
        req_err   = req_off[0];
        req_be    = 4'b0011 << req_off;
        req_wdata = rt_i << {req_off, 3'b000};
      end
      OpSw: begin
        req_err   = |req_off;
        req_be    = 4'b1111;
        req_wdata = rt_i;
      end
      default: req_err = 1'b1;
    endcase
  end

  // Load result, computed from the word on the bus in the completing read cycle.
  logic [15:0] lane;
  logic [31:0] load_result;

  assign lane = 16'(readdata_i >> {off_q, 3'b000});

  always_comb begin
    load_result = 32'h0;
    case (op_q)
      OpLb:  load_result = {{24{lane[7]}}, lane[7:0]};
      OpLbu: load_result = {24'h0, lane[7:0]};
      OpLh:  load_result = {{16{lane[15]}}, lane};
      OpLhu: load_result = {16'h0, lane};
      OpLw:  load_result = readdata_i;
      OpLwl: begin
        case (off_q)
          2'd0:    load_result = {readdata_i[7:0], rt_q[23:0]};
          2'd1:    load_result = {readdata_i[15:0], rt_q[15:0]};
          2'd2:    load_result = {readdata_i[23:0], rt_q[7:0]};
          default: load_result = readdata_i;
        endcase
      end
      OpLwr: begin
        case (off_q)
          2'd0:    load_result = readdata_i;
          2'd1:    load_result = {rt_q[31:24], readdata_i[31:8]};
          2'd2:    load_result = {rt_q[31:16], readdata_i[31:16]};
          default: load_result = {rt_q[31:8], readdata_i[31:24]};
        endcase
      end
      default: load_result = 32'h0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    off_d     = off_q;
    rt_d      = rt_q;
    data_d    = data_q;
    err_d     = err_q;
    address_d = address_q;
    read_d    = read_q;
    write_d   = write_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d   = opcode_i;
          off_d  = req_off;
          rt_d   = rt_i;
          data_d = 32'h0;
          err_d  = req_err;
          if (req_err) begin
            state_d = StDone;
          end else begin
            address_d = {effective_address_i[31:2], 2'b00};
            be_d      = req_be;
            if (req_load) begin
              state_d = StRead;
              read_d  = 1'b1;
            end else begin
              state_d = StWrite;
              write_d = 1'b1;
              wdata_d = req_wdata;
            end
          end
        end
      end
      StRead: begin
        if (!waitrequest_i) begin
          read_d  = 1'b0;
          data_d  = load_result;
          state_d = StDone;
        end
      end
      StWrite: begin
        if (!waitrequest_i) begin
          write_d = 1'b0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Async reset clears the request registers, so read/write drop without a clock edge.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      op_q      <= 6'h0;
      off_q     <= 2'b00;
      rt_q      <= 32'h0;
      data_q    <= 32'h0;
      err_q     <= 1'b0;
      address_q <= 32'h0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      off_q     <= off_d;
      rt_q      <= rt_d;
      data_q    <= data_d;
      err_q     <= err_d;
      address_q <= address_d;
      read_q    <= read_d;
      write_q   <= write_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign data_o       = data_q;
  assign addr_err_o   = err_q;
  assign address_o    = address_q;
  assign read_o       = read_q;
  assign write_o      = write_q;
  assign byteenable_o = be_q;
  assign writedata_o  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a wait-state bus slave model plus a scoreboard of
// expected completions.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        start_i;
  logic [5:0]  opcode_i;
  logic [31:0] effective_address_i;
  logic [31:0] rt_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;
  logic        addr_err_o;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  logic [3:0]  byteenable_o;
  logic [31:0] writedata_o;
  logic        waitrequest_i;
  logic [31:0] readdata_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          done_cyc;
    int          req_cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk                 (clk),
    .reset_ni            (reset_ni),
    .start_i             (start_i),
    .opcode_i            (opcode_i),
    .effective_address_i (effective_address_i),
    .rt_i                (rt_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .data_o              (data_o),
    .addr_err_o          (addr_err_o),
    .address_o           (address_o),
    .read_o              (read_o),
    .write_o             (write_o),
    .byteenable_o        (byteenable_o),
    .writedata_o         (writedata_o),
    .waitrequest_i       (waitrequest_i),
    .readdata_i          (readdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Called one time unit after an edge with the DUT idle; returns one cycle after done.
  task automatic run(input string name, input logic [5:0] op, input logic [31:0] ea,
                     input logic [31:0] rt, input logic [31:0] rd, input int waits,
                     input logic [31:0] exp_data, input logic exp_err,
                     input logic [3:0] exp_be, input logic [31:0] exp_wd,
                     input bit pulse_busy);
    exp_t e;
    int   c;
    int   nreq;
    bit   got_done;
    bit   is_store;
    e.data     = exp_data;
    e.err      = exp_err;
    e.done_cyc = exp_err ? 1 : 2 + waits;
    e.req_cyc  = exp_err ? 0 : waits + 1;
    sb.push_back(e);
    is_store            = op[3];
    start_i             = 1'b1;
    opcode_i            = op;
    effective_address_i = ea;
    rt_i                = rt;
    readdata_i          = rd;
    waitrequest_i       = (waits > 0);
    c        = 0;
    nreq     = 0;
    got_done = 1'b0;
    while (!got_done && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      // Scramble inputs after acceptance: the unit must work from its latched copies.
      start_i             = 1'b0;
      opcode_i            = 6'h2B;
      effective_address_i = $urandom;
      rt_i                = $urandom;
      if (pulse_busy && c == 1) begin
        start_i             = 1'b1;
        opcode_i            = 6'h23;
        effective_address_i = 32'h0;
      end
      if (read_o && write_o) chk({name, " rd_wr_overlap"}, 32'd1, 32'd0);
      if (read_o || write_o) begin
        nreq++;
        if (nreq == 1) begin
          chk({name, " address"}, address_o, {ea[31:2], 2'b00});
          chk({name, " byteenable"}, {28'h0, byteenable_o}, {28'h0, exp_be});
          chk({name, " write_dir"}, {31'h0, write_o}, {31'h0, is_store});
          if (is_store)
            chk({name, " writedata"}, writedata_o & lane_mask(exp_be),
                exp_wd & lane_mask(exp_be));
        end
        waitrequest_i = (nreq <= waits);
      end
      if (done_o) begin
        got_done = 1'b1;
        e = sb.pop_front();
        chk({name, " data"}, data_o, e.data);
        chk({name, " addr_err"}, {31'h0, addr_err_o}, {31'h0, e.err});
        chk({name, " done_cycle"}, c, e.done_cyc);
        chk({name, " req_cycles"}, nreq, e.req_cyc);
      end
    end
    chk({name, " timeout"}, {31'h0, got_done}, 32'd1);
    start_i       = 1'b0;
    waitrequest_i = 1'b0;
    @(posedge clk);
    #1;
    chk({name, " done_single"}, {31'h0, done_o}, 32'd0);
    chk({name, " idle_after"}, {31'h0, busy_o}, 32'd0);
    chk({name, " data_hold"}, data_o, exp_data);
  endtask

  initial begin
    reset_ni            = 1'b0;
    start_i             = 1'b0;
    opcode_i            = 6'h0;
    effective_address_i = 32'h0;
    rt_i                = 32'h0;
    waitrequest_i       = 1'b0;
    readdata_i          = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", {31'h0, busy_o}, 32'd0);
    chk("rst done", {31'h0, done_o}, 32'd0);
    chk("rst read", {31'h0, read_o}, 32'd0);
    chk("rst write", {31'h0, write_o}, 32'd0);
    chk("rst err", {31'h0, addr_err_o}, 32'd0);
    chk("rst data", data_o, 32'h0);
    chk("rst address", address_o, 32'h0);
    chk("rst wdata", writedata_o, 32'h0);
    chk("rst be", {28'h0, byteenable_o}, 32'h0);
    @(negedge clk);
    reset_ni = 1'b1;
    @(posedge clk);
    #1;

    run("lb",   6'h20, 32'h1003, 32'h0,        32'h80A1B2C3, 0, 32'hFFFFFF80, 1'b0, 4'b1000,
        32'h0, 1'b0);
    run("lbu",  6'h24, 32'h1003, 32'h0,        32'h80A1B2C3, 0, 32'h00000080, 1'b0, 4'b1000,
        32'h0, 1'b0);
    run("lh",   6'h21, 32'h2002, 32'h0,        32'h7FFE1234, 3, 32'h00007FFE, 1'b0, 4'b1100,
        32'h0, 1'b0);
    run("sh",   6'h29, 32'h3002, 32'hDEADBEEF, 32'h0,        0, 32'h0,        1'b0, 4'b1100,
        32'hBEEF0000, 1'b0);
    run("lwl1", 6'h22, 32'h4001, 32'h11223344, 32'hAABBCCDD, 0, 32'hCCDD3344, 1'b0, 4'b0011,
        32'h0, 1'b0);
    run("lwr1", 6'h26, 32'h4001, 32'h11223344, 32'hAABBCCDD, 0, 32'h11AABBCC, 1'b0, 4'b1110,
        32'h0, 1'b0);
    run("lw_mis", 6'h23, 32'h5002, 32'h0,      32'h0,        0, 32'h0,        1'b1, 4'b0000,
        32'h0, 1'b0);
    run("bad_op", 6'h2A, 32'h6000, 32'h0,      32'h0,        0, 32'h0,        1'b1, 4'b0000,
        32'h0, 1'b0);
    run("sw",   6'h2B, 32'h7000, 32'h12345678, 32'h0,        1, 32'h0,        1'b0, 4'b1111,
        32'h12345678, 1'b0);
    run("sb",   6'h28, 32'h8001, 32'h123456A5, 32'h0,        0, 32'h0,        1'b0, 4'b0010,
        32'h0000A500, 1'b0);
    run("lhu",  6'h25, 32'h9002, 32'h0,        32'h80011234, 0, 32'h00008001, 1'b0, 4'b1100,
        32'h0, 1'b0);
    run("lh0",  6'h21, 32'h9000, 32'h0,        32'h12348001, 1, 32'hFFFF8001, 1'b0, 4'b0011,
        32'h0, 1'b0);
    run("lw_busy", 6'h23, 32'hA000, 32'h0,     32'hCAFEF00D, 2, 32'hCAFEF00D, 1'b0, 4'b1111,
        32'h0, 1'b1);
    chk("lw_busy no_extra", {31'h0, busy_o}, 32'd0);
    run("sh_mis", 6'h29, 32'h3001, 32'h0,      32'h0,        0, 32'h0,        1'b1, 4'b0000,
        32'h0, 1'b0);
    run("lwl0", 6'h22, 32'hB000, 32'h11223344, 32'hAABBCCDD, 0, 32'hDD223344, 1'b0, 4'b0001,
        32'h0, 1'b0);
    run("lwl3", 6'h22, 32'hB003, 32'hFFFFFFFF, 32'h01020304, 0, 32'h01020304, 1'b0, 4'b1111,
        32'h0, 1'b0);
    run("lwr3", 6'h26, 32'hB003, 32'h11223344, 32'hAABBCCDD, 0, 32'h112233AA, 1'b0, 4'b1000,
        32'h0, 1'b0);
    run("lwr0", 6'h26, 32'hB000, 32'h11223344, 32'hAABBCCDD, 2, 32'hAABBCCDD, 1'b0, 4'b1111,
        32'h0, 1'b0);

    // Reset in the middle of a stalled read.
    start_i             = 1'b1;
    opcode_i            = 6'h23;
    effective_address_i = 32'hC000;
    waitrequest_i       = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("mid_rst read_before", {31'h0, read_o}, 32'd1);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("mid_rst read_async", {31'h0, read_o}, 32'd0);
    chk("mid_rst busy_async", {31'h0, busy_o}, 32'd0);
    @(negedge clk);
    reset_ni      = 1'b1;
    waitrequest_i = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst idle", {31'h0, busy_o}, 32'd0);
    chk("mid_rst read_after", {31'h0, read_o}, 32'd0);

    run("post_rst", 6'h20, 32'hD000, 32'h0, 32'h0000007F, 0, 32'h0000007F, 1'b0, 4'b0001,
        32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
